// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch port and the data port.
// One access in flight at a time: grant, one-cycle command, fixed-latency wait, one-cycle response.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic OwnIf   = 1'b0;
    localparam logic OwnData = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q;

    logic              grant;
    logic              grant_data;

    // Grant decision: from IDLE with arbitration, or from RESP to the other port only.
    always_comb begin
        grant      = 1'b0;
        grant_data = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (if_req && d_req) begin
                    grant      = 1'b1;
                    grant_data = (PRIO_MODE == 1) || (last_q == OwnIf);
                end else if (if_req || d_req) begin
                    grant      = 1'b1;
                    grant_data = d_req;
                end
            end
            StResp: begin
                if (owner_q == OwnData) begin
                    grant      = if_req;
                    grant_data = 1'b0;
                end else begin
                    grant      = d_req;
                    grant_data = 1'b1;
                end
            end
            default: begin
                grant      = 1'b0;
                grant_data = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                state_d = StWait;
                cnt_d   = CNT_W'(MEM_LAT - 1);
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    // Read data is only valid in this last wait cycle.
                    if (!we_q) begin
                        if (owner_q == OwnData) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = grant ? StAccess : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (grant) begin
            owner_d = grant_data;
            last_d  = grant_data;
            if (grant_data) begin
                addr_d  = d_addr;
                we_d    = d_we;
                wdata_d = d_wdata;
            end else begin
                addr_d = if_addr;
                we_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            owner_q    <= OwnIf;
            last_q     <= OwnData;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign mem_en    = (state_q == StAccess);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = (state_q == StResp) && (owner_q == OwnIf);
    assign d_ready   = (state_q == StResp) && (owner_q == OwnData);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LAT1/RR, LAT1/data-prio, LAT3/RR), each with its
// own fixed-latency memory model; directed vector table plus randomized traffic vs a reference.
module tb_mem_port_arbiter;
    localparam int N = 3;
    localparam int NV = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic        if_ready  [N];
    logic [31:0] if_rdata  [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic [31:0] d_addr    [N];
    logic [31:0] d_wdata   [N];
    logic        d_ready   [N];
    logic [31:0] d_rdata   [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        busy      [N];

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h20) ? 32'h12345678 : (32'h8C010000 | a);
    endfunction

    function automatic int lat_of(input int g);
        return (g == 2) ? 3 : 1;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int L = (g == 2) ? 3 : 1;
        localparam int P = (g == 1) ? 1 : 0;

        mem_port_arbiter #(
            .ADDR_W   (32),
            .DATA_W   (32),
            .MEM_LAT  (L),
            .PRIO_MODE(P)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_ready (if_ready[g]),
            .if_rdata (if_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_ready  (d_ready[g]),
            .d_rdata  (d_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );

        // Memory model: data valid exactly L cycles after the mem_en cycle, X otherwise.
        logic [31:0] wmem [64];
        logic [63:0] wr;
        logic [L-1:0] pv;
        logic [31:0] pd [L];
        logic [5:0]  idx;
        assign idx = mem_addr[g][7:2];

        always @(posedge clk) begin
            if (!reset) begin
                wr <= '0;
                pv <= '0;
            end else begin
                if (mem_en[g] && mem_we[g]) begin
                    wmem[idx] <= mem_wdata[g];
                    wr[idx]   <= 1'b1;
                end
                for (int i = L - 1; i > 0; i--) begin
                    pv[i] <= pv[i-1];
                    pd[i] <= pd[i-1];
                end
                pv[0] <= mem_en[g] && !mem_we[g];
                pd[0] <= wr[idx] ? wmem[idx] : init_word({24'h0, idx, 2'b00});
            end
        end
        assign mem_rdata[g] = pv[L-1] ? pd[L-1] : 32'hxxxxxxxx;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input int g, input string tag);
        chk($sformatf("%s i%0d if_ready", tag, g), 64'(if_ready[g]), 0);
        chk($sformatf("%s i%0d if_rdata", tag, g), 64'(if_rdata[g]), 0);
        chk($sformatf("%s i%0d d_ready", tag, g), 64'(d_ready[g]), 0);
        chk($sformatf("%s i%0d d_rdata", tag, g), 64'(d_rdata[g]), 0);
        chk($sformatf("%s i%0d mem_en", tag, g), 64'(mem_en[g]), 0);
        chk($sformatf("%s i%0d mem_we", tag, g), 64'(mem_we[g]), 0);
        chk($sformatf("%s i%0d mem_addr", tag, g), 64'(mem_addr[g]), 0);
        chk($sformatf("%s i%0d mem_wdata", tag, g), 64'(mem_wdata[g]), 0);
        chk($sformatf("%s i%0d busy", tag, g), 64'(busy[g]), 0);
    endtask

    typedef struct {
        int          inst;
        bit          use_if;
        bit          use_d;
        logic [31:0] ia;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        int          e_if;
        int          e_d;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
        bit          e_we0;
        logic [31:0] e_a0;
    } vec_t;

    function automatic vec_t mk(input int inst, input bit ui, input bit ud, input logic [31:0] ia,
                                input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                                input int eif, input int ed, input logic [31:0] eird,
                                input logic [31:0] edrd, input bit ewe, input logic [31:0] ea);
        vec_t v;
        v.inst = inst; v.use_if = ui; v.use_d = ud; v.ia = ia; v.dwe = dwe; v.da = da;
        v.dwd = dwd; v.e_if = eif; v.e_d = ed; v.e_ird = eird; v.e_drd = edrd;
        v.e_we0 = ewe; v.e_a0 = ea;
        return v;
    endfunction

    vec_t vecs [NV];
    logic [31:0] ref_mem [64];

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            if_req[i] = 1'b0; if_addr[i] = '0;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // inst, if, d, if_addr, d_we, d_addr, d_wdata, if_cyc, d_cyc, if_rdata, d_rdata, we0, addr0
        vecs[0]  = mk(0, 1'b1, 1'b0, 32'h04, 1'b0, 32'h00, 32'h0, 3, 0,
                      32'h8C010004, 32'h0, 1'b0, 32'h04);
        vecs[1]  = mk(0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h10, 32'hDEADBEEF, 0, 3,
                      32'h8C010004, 32'h0, 1'b1, 32'h10);
        vecs[2]  = mk(0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h10, 32'h0, 0, 3,
                      32'h8C010004, 32'hDEADBEEF, 1'b0, 32'h10);
        vecs[3]  = mk(0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h0C, 32'h0, 3, 6,
                      32'h8C010008, 32'h8C01000C, 1'b0, 32'h08);
        vecs[4]  = mk(0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h18, 32'h0BADF00D, 3, 6,
                      32'h8C010014, 32'h8C01000C, 1'b0, 32'h14);
        vecs[5]  = mk(0, 1'b1, 1'b0, 32'h1C, 1'b0, 32'h00, 32'h0, 3, 0,
                      32'h8C01001C, 32'h8C01000C, 1'b0, 32'h1C);
        vecs[6]  = mk(0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h18, 32'h0, 6, 3,
                      32'h8C010004, 32'h0BADF00D, 1'b0, 32'h18);
        vecs[7]  = mk(1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h08, 32'h0, 6, 3,
                      32'h8C010004, 32'h8C010008, 1'b0, 32'h08);
        vecs[8]  = mk(1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h00, 32'h55AA55AA, 6, 3,
                      32'h8C01000C, 32'h8C010008, 1'b1, 32'h00);
        vecs[9]  = mk(2, 1'b0, 1'b1, 32'h00, 1'b0, 32'h20, 32'h0, 0, 5,
                      32'h0, 32'h12345678, 1'b0, 32'h20);
        vecs[10] = mk(2, 1'b1, 1'b1, 32'h04, 1'b0, 32'h08, 32'h0, 5, 10,
                      32'h8C010004, 32'h8C010008, 1'b0, 32'h04);

        idle_all();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < N; g++) chk_zero(g, "reset");
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            int g, got_if, got_d, n_if, n_d, n_en;
            logic busy1, we0;
            logic [31:0] a0, wd0;
            g = vecs[v].inst;
            got_if = 0; got_d = 0; n_if = 0; n_d = 0; n_en = 0;
            busy1 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
            if_req[g] = vecs[v].use_if; if_addr[g] = vecs[v].ia;
            d_req[g] = vecs[v].use_d; d_we[g] = vecs[v].dwe;
            d_addr[g] = vecs[v].da; d_wdata[g] = vecs[v].dwd;
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                if (k == 1) busy1 = busy[g];
                if (mem_en[g]) begin
                    if (n_en == 0) begin
                        we0 = mem_we[g]; a0 = mem_addr[g]; wd0 = mem_wdata[g];
                    end
                    n_en++;
                end
                if (if_ready[g]) begin
                    n_if++;
                    if (got_if == 0) got_if = k;
                    if_req[g] = 1'b0;
                end
                if (d_ready[g]) begin
                    n_d++;
                    if (got_d == 0) got_d = k;
                    d_req[g] = 1'b0;
                end
            end
            chk($sformatf("v%0d if_ready cycle", v), 64'(got_if), 64'(vecs[v].e_if));
            chk($sformatf("v%0d d_ready cycle", v), 64'(got_d), 64'(vecs[v].e_d));
            chk($sformatf("v%0d if_ready pulses", v), 64'(n_if), 64'(vecs[v].use_if));
            chk($sformatf("v%0d d_ready pulses", v), 64'(n_d), 64'(vecs[v].use_d));
            chk($sformatf("v%0d if_rdata", v), 64'(if_rdata[g]), 64'(vecs[v].e_ird));
            chk($sformatf("v%0d d_rdata", v), 64'(d_rdata[g]), 64'(vecs[v].e_drd));
            chk($sformatf("v%0d mem_en count", v), 64'(n_en),
                64'(int'(vecs[v].use_if) + int'(vecs[v].use_d)));
            chk($sformatf("v%0d first mem_we", v), 64'(we0), 64'(vecs[v].e_we0));
            chk($sformatf("v%0d first mem_addr", v), 64'(a0), 64'(vecs[v].e_a0));
            if (vecs[v].e_we0) chk($sformatf("v%0d mem_wdata", v), 64'(wd0), 64'(vecs[v].dwd));
            chk($sformatf("v%0d busy in ACCESS", v), 64'(busy1), 1);
            chk($sformatf("v%0d busy at end", v), 64'(busy[g]), 0);
        end

        // Reset during WAIT of an IF read on instance 0.
        begin
            int n_if;
            n_if = 0;
            if_req[0] = 1'b1; if_addr[0] = 32'h24;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            #1;
            chk_zero(0, "midreset");
            @(negedge clk);
            if_req[0] = 1'b0;
            reset = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (if_ready[0]) n_if++;
            end
            chk("midreset no if_ready after release", 64'(n_if), 0);
            chk("midreset busy after release", 64'(busy[0]), 0);
        end

        // Randomized traffic: each port is an independent requester; reference memory in program
        // order, plus latency window and one memory command per completed access.
        for (int g = 0; g < N; g++) begin
            int L, age_if, age_d, n_en, n_done;
            bit pend_if, pend_d, just_if, just_d, we_cur;
            logic [31:0] a_if, a_d, wd_cur;
            L = lat_of(g);
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(32'(i * 4));
            pend_if = 1'b0; pend_d = 1'b0; age_if = 0; age_d = 0; n_en = 0; n_done = 0;
            a_if = '0; a_d = '0; we_cur = 1'b0; wd_cur = '0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                just_if = 1'b0; just_d = 1'b0;
                if (pend_if) age_if++;
                if (pend_d) age_d++;
                if (mem_en[g]) n_en++;
                if (if_ready[g]) begin
                    chk($sformatf("rnd%0d if_ready while requesting", g), 64'(pend_if), 1);
                    if (pend_if) begin
                        chk($sformatf("rnd%0d if latency %0d", g, age_if),
                            64'(age_if >= L + 2 && age_if <= 2 * L + 4), 1);
                        chk($sformatf("rnd%0d if_rdata @%h", g, a_if), 64'(if_rdata[g]),
                            64'(ref_mem[a_if[7:2]]));
                        n_done++;
                    end
                    pend_if = 1'b0; if_req[g] = 1'b0; just_if = 1'b1;
                end
                if (d_ready[g]) begin
                    chk($sformatf("rnd%0d d_ready while requesting", g), 64'(pend_d), 1);
                    if (pend_d) begin
                        chk($sformatf("rnd%0d d latency %0d", g, age_d),
                            64'(age_d >= L + 2 && age_d <= 2 * L + 4), 1);
                        if (we_cur) ref_mem[a_d[7:2]] = wd_cur;
                        else chk($sformatf("rnd%0d d_rdata @%h", g, a_d), 64'(d_rdata[g]),
                                 64'(ref_mem[a_d[7:2]]));
                        n_done++;
                    end
                    pend_d = 1'b0; d_req[g] = 1'b0; just_d = 1'b1;
                end
                if (pend_if && age_if > 2 * L + 6) begin
                    n_chk++; n_err++;
                    $display("FAIL rnd%0d if timeout: waited %0d cycles, limit %0d", g, age_if,
                             2 * L + 4);
                    pend_if = 1'b0; if_req[g] = 1'b0;
                end
                if (pend_d && age_d > 2 * L + 6) begin
                    n_chk++; n_err++;
                    $display("FAIL rnd%0d d timeout: waited %0d cycles, limit %0d", g, age_d,
                             2 * L + 4);
                    pend_d = 1'b0; d_req[g] = 1'b0;
                end
                if (c < 560) begin
                    if (!pend_if && !just_if && $urandom_range(0, 2) == 0) begin
                        a_if = 32'($urandom_range(0, 7) * 4);
                        if_addr[g] = a_if; if_req[g] = 1'b1; pend_if = 1'b1; age_if = 0;
                    end
                    if (!pend_d && !just_d && $urandom_range(0, 2) == 0) begin
                        a_d = 32'($urandom_range(0, 7) * 4);
                        we_cur = 1'($urandom_range(0, 1));
                        wd_cur = $urandom;
                        d_addr[g] = a_d; d_we[g] = we_cur; d_wdata[g] = wd_cur;
                        d_req[g] = 1'b1; pend_d = 1'b1; age_d = 0;
                    end
                end
            end
            chk($sformatf("rnd%0d mem_en per access", g), 64'(n_en), 64'(n_done));
            chk($sformatf("rnd%0d busy when drained", g), 64'(busy[g]), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
